// File: rtl/sram_macro_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram1rw_macro                                                 |
// | Purpose  : Behavioural stand-in for an SRAM1RW<DEPTH>x<WIDTH> hard macro.|
// |            Active-low chip select, write enable and output enable; the   |
// |            read port is registered, so O is valid after the access edge. |
// | Ports    : CE  clock / chip clock      CSB  chip select (active low)     |
// |            WEB write enable (low)      OEB  read enable (low)            |
// |            A   word address            I/O  write / read data            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram1rw_macro #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CE,
  input  logic             CSB,
  input  logic             WEB,
  input  logic             OEB,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CE) begin
    if (!CSB && !WEB) mem_q[A] <= I;
    if (!CSB && !OEB) O <= mem_q[A];
  end

endmodule

// +--------------------------------------------------------------------------+
// | Module   : sram_macro_array                                              |
// | Purpose  : Tiled single-port SRAM built from a ROWS x COLS grid of       |
// |            SRAM1RW macros, with registered row select, optional zero    |
// |            fill after reset, read-valid strobe and read-data hold.      |
// | Ports    : clock       array clock, also every macro CE                 |
// |            reset_n     asynchronous active-low reset                    |
// |            RW0_addr    word address        RW0_wdata  write data        |
// |            RW0_wmask   per-column write enable                          |
// |            RW0_en      request strobe      RW0_wmode  1=write 0=read    |
// |            RW0_ready   requests accepted   RW0_rvalid fresh read data   |
// |            RW0_rdata   read data, held between reads                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram_macro_array #(
  parameter int ADDR_BITS     = 12,
  parameter int DATA_BITS     = 32,
  parameter int MACRO_DEPTH   = 2048,
  parameter int MACRO_WIDTH   = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [ADDR_BITS-1:0]                 RW0_addr,
  input  logic [DATA_BITS-1:0]                 RW0_wdata,
  input  logic [DATA_BITS/MACRO_WIDTH-1:0]     RW0_wmask,
  input  logic                                 RW0_en,
  input  logic                                 RW0_wmode,
  output logic                                 RW0_ready,
  output logic                                 RW0_rvalid,
  output logic [DATA_BITS-1:0]                 RW0_rdata
);

  localparam int COLS = DATA_BITS / MACRO_WIDTH;
  localparam int ROWS = (1 << ADDR_BITS) / MACRO_DEPTH;
  localparam int MA   = $clog2(MACRO_DEPTH);
  localparam int RB   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Reset parks the FSM in INIT directly so that the zero fill takes exactly
  // MACRO_DEPTH edges after release; without init, OFF costs one edge.
  localparam state_e C_ST_RESET = (INIT_ON_RESET != 0) ? ST_INIT : ST_OFF;

  state_e                          state_q;
  logic   [MA-1:0]                 icnt_q;
  logic                            ready_q;
  logic                            rd_pend_q;
  logic   [DATA_BITS-1:0]          hold_q;
  logic   [DATA_BITS-1:0]          hold_d;

  logic                            w_init;
  logic                            w_accept;
  logic                            w_rd_accept;
  logic                            w_wmode_eff;
  logic   [RB-1:0]                 w_row;
  logic   [RB-1:0]                 w_rd_row;
  logic   [MA-1:0]                 w_maddr;
  logic   [DATA_BITS-1:0]          w_wdata;
  logic   [COLS-1:0]               w_mask;
  logic   [ROWS-1:0]               w_sel;
  logic   [ROWS-1:0][DATA_BITS-1:0] w_mo;
  logic   [DATA_BITS-1:0]          w_rd_data;

  // The FSM already sits in INIT while reset is held; gating with reset_n
  // keeps every macro deselected until reset is released.
  assign w_init      = (state_q == ST_INIT) && reset_n;
  assign w_accept    = RW0_en && ready_q;
  assign w_rd_accept = w_accept && !RW0_wmode;
  assign w_wmode_eff = w_init || (w_accept && RW0_wmode);
  assign w_maddr     = w_init ? icnt_q : RW0_addr[MA-1:0];
  assign w_wdata     = w_init ? '0 : RW0_wdata;
  assign w_mask      = w_init ? '1 : RW0_wmask;

  // Row split and registered read row; both collapse to zero for one row.
  if (ROWS > 1) begin : g_rows_multi
    logic [RB-1:0] row_q;

    assign w_row    = RW0_addr[ADDR_BITS-1:MA];
    assign w_rd_row = row_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        row_q <= '0;
      end else if (w_rd_accept) begin
        row_q <= w_row;
      end
    end
  end else begin : g_rows_single
    assign w_row    = '0;
    assign w_rd_row = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign w_sel[r] = w_init || (w_accept && (w_row == RB'(r)));

    for (genvar c = 0; c < COLS; c++) begin : g_col
      sram1rw_macro #(
        .DEPTH (MACRO_DEPTH),
        .WIDTH (MACRO_WIDTH),
        .AW    (MA)
      ) u_macro (
        .CE  (clock),
        .CSB (~w_sel[r]),
        .WEB (~(w_wmode_eff && w_mask[c])),
        .OEB (~(!w_wmode_eff && w_sel[r])),
        .A   (w_maddr),
        .I   (w_wdata[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .O   (w_mo[r][c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  assign w_rd_data = w_mo[w_rd_row];

  // Fresh macro data on the valid cycle, otherwise the last read; the same
  // value is what the hold register captures at the end of the cycle.
  assign hold_d     = rd_pend_q ? w_rd_data : hold_q;
  assign RW0_rdata  = hold_d;
  assign RW0_rvalid = rd_pend_q;
  assign RW0_ready  = ready_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= C_ST_RESET;
      icnt_q    <= '0;
      ready_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_pend_q <= w_rd_accept;
      hold_q    <= hold_d;
      case (state_q)
        ST_OFF: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
        ST_INIT: begin
          icnt_q <= icnt_q + 1'b1;
          if (icnt_q == '1) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= C_ST_RESET;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
